// File: rtl/sop_pkg.sv
// -----------------------------------------------------------------------------
// sop_pkg
// Shared definitions for the SOP operand loader and its self-check MAC.
//   NPAIR / NOPS   : pairs per frame and operands per frame
//   SOP_W / SOP_QW : default operand and result widths
//   occ_t          : ping-pong bank occupancy states
//   xform_t        : per-pair operand transform used by the self-check MAC
//   XF_TABLE       : pair index -> transform, packed 3 bits per pair, pair 0 in LSBs
//   pair_xform()   : table lookup
//   xform()        : applies a transform to one operand, wrapping in SOP_W bits
// -----------------------------------------------------------------------------
package sop_pkg;

    localparam int NPAIR  = 8;
    localparam int NOPS   = 2 * NPAIR;
    localparam int IDXW   = $clog2(NPAIR);
    localparam int SOP_W  = 6;
    localparam int SOP_QW = 9;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    typedef enum logic [2:0] {
        XF_INV,
        XF_NEG,
        XF_ASR4,
        XF_SHL4,
        XF_PASS,
        XF_REP0
    } xform_t;

    localparam logic [3*NPAIR-1:0] XF_TABLE = {
        XF_NEG,   // pair 7
        XF_REP0,  // pair 6
        XF_INV,   // pair 5
        XF_PASS,  // pair 4
        XF_SHL4,  // pair 3
        XF_ASR4,  // pair 2
        XF_NEG,   // pair 1
        XF_INV    // pair 0
    };

    function automatic xform_t pair_xform(input logic [IDXW-1:0] idx);
        return xform_t'(XF_TABLE[3*idx +: 3]);
    endfunction

    function automatic logic signed [SOP_W-1:0] xform(
        input logic signed [SOP_W-1:0] x,
        input xform_t                  xf
    );
        logic signed [SOP_W-1:0] r;
        case (xf)
            XF_INV:  r = ~x;
            XF_NEG:  r = -x;
            XF_ASR4: r = x >>> 4;
            XF_SHL4: r = x <<< 4;
            XF_PASS: r = x;
            XF_REP0: r = {SOP_W{x[0]}};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sop_serial_mac.sv
// -----------------------------------------------------------------------------
// sop_serial_mac
// Serial multiply-accumulate for one ping-pong bank of the loader's self-check.
// Each enabled cycle both operands of the pair are transformed according to the
// pair index, sign-extended to QW, multiplied, and added to the accumulator
// modulo 2^QW. i_clear restarts the sum with the current product.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_idx      : pair index within the frame (selects the transform)
//   i_x, i_y   : even / odd operand of the pair
//   i_clear    : first pair of a frame, drop the previous sum
//   i_en       : pair accepted into this bank
//   o_acc      : running sum of products (QW bits)
// -----------------------------------------------------------------------------
module sop_serial_mac
    import sop_pkg::*;
#(
    parameter int W  = SOP_W,
    parameter int QW = SOP_QW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IDXW-1:0]        i_idx,
    input  logic signed [W-1:0]    i_x,
    input  logic signed [W-1:0]    i_y,
    input  logic                   i_clear,
    input  logic                   i_en,
    output logic [QW-1:0]          o_acc
);

    xform_t                 w_xf;
    logic signed [W-1:0]    w_tx;
    logic signed [W-1:0]    w_ty;
    logic signed [QW-1:0]   w_ex;
    logic signed [QW-1:0]   w_ey;
    logic signed [QW-1:0]   w_prod;
    logic [QW-1:0]          r_acc;

    assign w_xf = pair_xform(i_idx);
    assign w_tx = xform(i_x, w_xf);
    assign w_ty = xform(i_y, w_xf);

    assign w_ex   = {{(QW-W){w_tx[W-1]}}, w_tx};
    assign w_ey   = {{(QW-W){w_ty[W-1]}}, w_ty};
    // Only QW bits of the product matter because the sum is kept modulo 2^QW.
    assign w_prod = w_ex * w_ey;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= (i_clear ? '0 : r_acc) + w_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/sop_operand_loader.sv
// -----------------------------------------------------------------------------
// sop_operand_loader
// Collects operand pairs (8 per frame) into a two-deep ping-pong bank and
// presents each complete 16-operand frame in parallel to the SOP stage with a
// valid/ready handshake. Define SOP_SELFCHECK_EN to build a serial MAC per bank
// that predicts q and compares it with q_in on each output handshake.
//
// Occupancy FSM
//   state     | meaning
//   OCC_EMPTY | no complete frame; assembling into bank[wr_ptr]
//   OCC_ONE   | one frame presented from bank[rd_ptr]; other bank assembling
//   OCC_FULL  | both banks hold complete frames; input stalled
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : pair stream handshake
//   in_sop              : this pair is pair 0 (restarts a partial frame)
//   in_data             : [W-1:0] even operand, [2W-1:W] odd operand
//   out_valid/out_ready : frame handshake
//   out_ops             : operand k at [k*W +: W]
//   frame_err           : one-cycle pulse, partial frame dropped
//   q_in                : SOP result for the presented frame (self-check only)
//   chk_fail            : one-cycle pulse on q_in mismatch (self-check only)
//   chk_err             : sticky mismatch flag (self-check only)
// -----------------------------------------------------------------------------
module sop_operand_loader
    import sop_pkg::*;
#(
    parameter int W  = SOP_W,
    parameter int QW = SOP_QW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sop,
    input  logic [2*W-1:0]      in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NOPS*W-1:0]   out_ops,
    output logic                frame_err,
    input  logic [QW-1:0]       q_in,
    output logic                chk_fail,
    output logic                chk_err
);

    localparam int PW = 2 * W;
    localparam int BW = NOPS * W;

    occ_t               r_state;
    occ_t               w_state_next;
    logic [IDXW-1:0]    r_idx;
    logic [IDXW-1:0]    w_idx_eff;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_frame_err;
    logic [BW-1:0]      r_bank [2];
    logic [BW-1:0]      w_bank_next;

    logic               w_accept;
    logic               w_restart;
    logic               w_push;
    logic               w_pop;

    assign w_accept  = in_valid & in_ready;
    assign w_restart = w_accept & in_sop & (r_idx != '0);
    // A restart pair is written as pair 0 of a fresh frame.
    assign w_idx_eff = w_restart ? '0 : r_idx;
    assign w_push    = w_accept & (w_idx_eff == IDXW'(NPAIR-1));
    assign w_pop     = out_valid & out_ready;

    // ---------------- occupancy FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OCC_EMPTY: if (w_push) w_state_next = OCC_ONE;
            OCC_ONE: begin
                if (w_push && !w_pop)      w_state_next = OCC_FULL;
                else if (w_pop && !w_push) w_state_next = OCC_EMPTY;
            end
            OCC_FULL:  if (w_pop) w_state_next = OCC_ONE;
            default:   w_state_next = OCC_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (r_state)
            OCC_EMPTY: begin in_ready = 1'b1; out_valid = 1'b0; end
            OCC_ONE:   begin in_ready = 1'b1; out_valid = 1'b1; end
            OCC_FULL:  begin in_ready = 1'b0; out_valid = 1'b1; end
            default:   begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    // ---------------- pair index and pointers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_restart;
            if (w_accept) begin
                r_idx <= w_push ? '0 : w_idx_eff + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // ---------------- bank storage ----------------
    // A restart wipes the partial bank so no operand of the dropped frame can
    // survive into the new one.
    always_comb begin
        w_bank_next = w_restart ? '0 : r_bank[r_wr_ptr];
        w_bank_next[int'(w_idx_eff)*PW +: PW] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_accept && (r_wr_ptr == 1'(b))) begin
                    r_bank[b] <= w_bank_next;
                end
            end
        end
    end

    // The presented bank is never written while presented: in OCC_ONE the
    // write pointer targets the other bank, in OCC_FULL input is stalled.
    assign out_ops   = r_bank[r_rd_ptr];
    assign frame_err = r_frame_err;

    // ---------------- optional result self-check ----------------
`ifdef SOP_SELFCHECK_EN
    logic [QW-1:0]  w_acc [2];
    logic           w_mismatch;
    logic           r_chk_fail;
    logic           r_chk_err;

    for (genvar b = 0; b < 2; b++) begin : g_mac
        sop_serial_mac #(
            .W  (W),
            .QW (QW)
        ) u_mac (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_idx   (w_idx_eff),
            .i_x     (in_data[W-1:0]),
            .i_y     (in_data[PW-1:W]),
            .i_clear (w_idx_eff == '0),
            .i_en    (w_accept && (r_wr_ptr == 1'(b))),
            .o_acc   (w_acc[b])
        );
    end

    assign w_mismatch = w_pop && (q_in != w_acc[r_rd_ptr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_fail <= 1'b0;
            r_chk_err  <= 1'b0;
        end else begin
            r_chk_fail <= w_mismatch;
            if (w_mismatch) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_fail = r_chk_fail;
    assign chk_err  = r_chk_err;
`else
    logic w_unused_q;
    assign w_unused_q = ^q_in;
    assign chk_fail   = 1'b0;
    assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sop_operand_loader.sv
module tb_sop_operand_loader;

    localparam int W  = 6;
    localparam int QW = 9;
`ifdef SOP_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sop = 1'b0;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   in_data = '0;
    logic [QW-1:0]    q_in = '0;
    logic             in_ready, out_valid, frame_err, chk_fail, chk_err;
    logic [16*W-1:0]  out_ops;

    int errors = 0;
    int checks = 0;

    sop_operand_loader #(.W(W), .QW(QW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ops   (out_ops),
        .frame_err (frame_err),
        .q_in      (q_in),
        .chk_fail  (chk_fail),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [95:0] ops;
        logic [8:0]  exp;
    } frame_t;

    frame_t      m_q[$];
    logic [95:0] m_part;
    int          m_idx;
    int          m_acc;
    bit          m_ferr, m_cfail, m_cerr;

    function automatic int wrap6(input int v);
        int r;
        r = ((v % 64) + 64) % 64;
        if (r >= 32) r -= 64;
        return r;
    endfunction

    // Transform of one operand value for a given pair index, as plain integers.
    function automatic int mxf(input int i, input int x);
        case (i)
            0, 5:    return wrap6(-x - 1);
            1, 7:    return wrap6(-x);
            2:       return (x - (((x % 16) + 16) % 16)) / 16;
            3:       return wrap6(x * 16);
            4:       return x;
            default: return (x % 2 != 0) ? -1 : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_part = '0;
        m_idx  = 0;
        m_acc  = 0;
        m_ferr = 0;
        m_cfail = 0;
        m_cerr = 0;
    endtask

    task automatic model_step();
        bit rdy, vld, fe, cf;
        logic signed [5:0] sx, sy;
        frame_t f;
        rdy = (m_q.size() < 2);
        vld = (m_q.size() > 0);
        fe = 0;
        cf = 0;
        if (vld && out_ready) begin
`ifdef SOP_SELFCHECK_EN
            if (q_in != m_q[0].exp) cf = 1;
`endif
            void'(m_q.pop_front());
        end
        if (in_valid && rdy) begin
            if (in_sop && m_idx != 0) begin
                fe = 1;
                m_idx = 0;
                m_part = '0;
            end
            if (m_idx == 0) m_acc = 0;
            m_part[m_idx*12 +: 12] = in_data;
            sx = in_data[5:0];
            sy = in_data[11:6];
            m_acc += mxf(m_idx, int'(sx)) * mxf(m_idx, int'(sy));
            m_idx++;
            if (m_idx == 8) begin
                f.ops = m_part;
                f.exp = 9'(((m_acc % 512) + 512) % 512);
                m_q.push_back(f);
                m_idx = 0;
            end
        end
        m_ferr  = fe;
        m_cfail = cf;
        m_cerr  = m_cerr | cf;
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive inputs, advance the model on the clock edge.
    task automatic step(input bit v, input bit sop, input logic [11:0] d,
                        input bit ordy, input bit qbad);
        in_valid  = v;
        in_sop    = sop;
        in_data   = d;
        out_ready = ordy;
        if (m_q.size() > 0) q_in = m_q[0].exp + (qbad ? 9'd1 : 9'd0);
        else                q_in = 9'($urandom);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", in_ready, m_q.size() < 2);
                chk("out_valid", out_valid, m_q.size() > 0);
                if (m_q.size() > 0) chk("out_ops", out_ops, m_q[0].ops);
                chk("frame_err", frame_err, m_ferr);
                chk("chk_fail", chk_fail, m_cfail);
                chk("chk_err", chk_err, m_cerr);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] d;
        logic [95:0] fa, fb, f4, f5, f6;
        int n;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ops", out_ops, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_chk_fail", chk_fail, 0);
        chk("rst_chk_err", chk_err, 0);
        rst_n = 1'b1;

        // 1: all-zero frame, expected q = 2
        for (int i = 0; i < 8; i++) step(1, i == 0, 12'h000, 0, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_ops", out_ops, 0);
        chk("t1_model_exp", m_q[0].exp, 9'd2);
        step(0, 0, 12'h000, 1, 0);
        chk("t1_chk_fail", chk_fail, 0);

        // 2: all-one frame, expected q = 268; then a deliberate mismatch
        for (int i = 0; i < 8; i++) step(1, i == 0, 12'h041, 0, 0);
        chk("t2_model_exp", m_q[0].exp, 9'h10C);
        step(0, 0, 12'h000, 1, 0);
        chk("t2_pass_chk_fail", chk_fail, 0);
        for (int i = 0; i < 8; i++) step(1, i == 0, 12'h041, 0, 0);
        step(0, 0, 12'h000, 1, 1);
        chk("t2_bad_chk_fail", chk_fail, SC);
        chk("t2_bad_chk_err", chk_err, SC);
        step(0, 0, 12'h000, 0, 0);
        chk("t2_fail_pulse_end", chk_fail, 0);
        chk("t2_err_sticky", chk_err, SC);

        // 3: back-pressure, three frames offered, two buffered
        n = 0;
        fa = '0;
        fb = '0;
        for (int c = 0; c < 24; c++) begin
            d = 12'($urandom);
            if (m_q.size() < 2) begin
                if (n < 8) fa[n*12 +: 12] = d;
                else       fb[(n-8)*12 +: 12] = d;
                n++;
            end
            step(1, m_idx == 0, d, 0, 0);
        end
        chk("t3_accepts", n, 16);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_stable", out_ops, fa);
        step(0, 0, 12'h000, 1, 0);
        chk("t3_second", out_ops, fb);
        step(0, 0, 12'h000, 1, 0);
        chk("t3_drained", out_valid, 0);

        // 4: sop at pair index 5 restarts the frame
        for (int i = 0; i < 5; i++) step(1, i == 0, 12'($urandom), 0, 0);
        f4 = '0;
        d = 12'($urandom);
        f4[11:0] = d;
        step(1, 1, d, 0, 0);
        chk("t4_frame_err", frame_err, 1);
        for (int i = 1; i < 8; i++) begin
            d = 12'($urandom);
            f4[i*12 +: 12] = d;
            step(1, 0, d, 0, 0);
        end
        chk("t4_out_valid", out_valid, 1);
        chk("t4_ops", out_ops, f4);
        step(0, 0, 12'h000, 1, 0);

        // 5: pair 7 accepted together with an output handshake at count 1
        for (int i = 0; i < 8; i++) step(1, i == 0, 12'($urandom), 0, 0);
        f5 = '0;
        for (int i = 0; i < 8; i++) begin
            d = 12'($urandom);
            f5[i*12 +: 12] = d;
            step(1, i == 0, d, i == 7, 0);
        end
        chk("t5_out_valid", out_valid, 1);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_ops", out_ops, f5);
        step(0, 0, 12'h000, 1, 0);
        chk("t5_drained", out_valid, 0);

        // 6: asynchronous reset mid-frame with a frame presented
        for (int i = 0; i < 8; i++) step(1, i == 0, 12'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) step(1, i == 0, 12'($urandom), 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_in_ready", in_ready, 1);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_ops", out_ops, 0);
        chk("t6_frame_err", frame_err, 0);
        chk("t6_chk_fail", chk_fail, 0);
        chk("t6_chk_err", chk_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        f6 = '0;
        for (int i = 0; i < 8; i++) begin
            d = 12'($urandom);
            f6[i*12 +: 12] = d;
            step(1, 0, d, 0, 0);
        end
        chk("t6_out_valid_after", out_valid, 1);
        chk("t6_ops_after", out_ops, f6);
        step(0, 0, 12'h000, 1, 0);

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            bit v, sop;
            v   = ($urandom_range(3) != 0);
            sop = (m_idx == 0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
            step(v, sop, 12'($urandom), $urandom_range(9) < 7, $urandom_range(7) == 0);
        end
        step(0, 0, 12'h000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
